uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416: clk cycles per bit period; legal range >= 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_EN, default 0: 1 = parity bit present after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 rx  input  1  asynchronous serial line; idles high.
REQ-009 rx_data  output  DATA_BITS  received word, LSB = first data bit on the line.
REQ-010 rx_valid  output  1  rx_data and the error flags are valid; held until accepted.
REQ-011 rx_ready  input  1  consumer accepts the word in any cycle where rx_valid=1 and rx_ready=1.
REQ-012 parity_err  output  1  parity mismatch on the word currently presented.
REQ-013 frame_err  output  1  at least one stop bit was sampled low on the word currently presented.
REQ-014 overrun  output  1  one-cycle pulse: a completed frame was dropped.

Function
REQ-015 rx passes through a 2-flop synchroniser (both flops reset to 1); all FSM decisions use the synchronised value.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-017 IDLE: synchronised rx = 0 -> START, bit counter cleared, baud counter cleared.
REQ-018 START: wait CLKS_PER_BIT/2 (integer division) cycles, then sample; 0 -> DATA, 1 -> IDLE (false start, no output activity).
REQ-019 DATA: sample once every CLKS_PER_BIT cycles; store DATA_BITS samples LSB first; after the last one -> PARITY if PARITY_EN=1, otherwise STOP.
REQ-020 PARITY: sample after CLKS_PER_BIT cycles; mismatch = XOR of data bits and parity bit not equal to PARITY_ODD.
REQ-021 STOP: sample STOP_BITS times at CLKS_PER_BIT spacing; any low sample sets the frame error.
REQ-022 Frame completion occurs on the final stop sample; rx_data, parity_err and frame_err load together and rx_valid asserts on the next edge.
REQ-023 After completion: frame_err=0 -> IDLE; frame_err=1 -> BREAK_WAIT.
REQ-024 BREAK_WAIT -> IDLE only after synchronised rx = 1 is seen, so a held-low line yields exactly one word.
REQ-025 Baud counter width = clog2(CLKS_PER_BIT); it wraps to 0 on every sample point; no free-running overflow.
REQ-026 rx_valid clears on the cycle after acceptance, unless a new frame completes in the same cycle.
REQ-027 Completion while rx_valid=1 and not accepted in that cycle: the new frame is discarded; old rx_data and flags are retained; overrun pulses for 1 cycle.
REQ-028 Completion in the same cycle as acceptance: the new word loads, rx_valid stays 1, and no overrun occurs.
REQ-029 Reception continues independently of rx_ready; the FSM never stalls.

Reset
REQ-030 rst_n=0 immediately forces: state = IDLE; counters = 0; synchroniser flops = 1; rx_data = 0; rx_valid = 0; parity_err = 0; frame_err = 0; overrun = 0.
REQ-031 Reset during any state abandons the partial frame; no word is produced from it after release.
REQ-032 After rst_n deasserts, the first falling edge on rx starts a new frame normally.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-033 8N1, send 0xA5 with rx_ready=1 -> rx_valid for 1 cycle, rx_data=0xA5, parity_err=0, frame_err=0.
REQ-034 PARITY_EN=1, PARITY_ODD=0, send 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-035 rx low pulse of 4 clk, then high -> no rx_valid, FSM back in IDLE; the following valid 0x5A frame is received correctly.
REQ-036 rx_ready=0, back-to-back frames 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; raising rx_ready gives one accept and rx_valid drops.
REQ-037 rx held low for 30 bit times -> exactly one word, rx_data=0x00, frame_err=1; after rx returns high, a 0x81 frame is received with frame_err=0.
REQ-038 rst_n pulsed low mid-DATA of a frame -> all outputs 0 immediately; no word from that frame; the next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle: word, status flags and the consumer ready.
// master = receiver driving the word, slave = consumer.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready output register with overrun reporting.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    uart_rx_param_if.master  bus
);
    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);
    localparam logic            ParOn    = (PARITY_EN != 0);
    localparam logic            ParOdd   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreakWait
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;

    logic tick, accept, complete, frame_fe;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        pe_d     = pe_q;
        fe_d     = fe_q;
        ovr_d    = 1'b0;
        complete = 1'b0;
        frame_fe = ferr_q;
        tick     = (cnt_q == CntLast);
        accept   = valid_q & bus.rx_ready;

        unique case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = ParOn ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StParity: begin
                if (tick) begin
                    cnt_d   = '0;
                    perr_d  = ((^shift_q) ^ rx_sync_q) != ParOdd;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStop: begin
                if (tick) begin
                    cnt_d    = '0;
                    frame_fe = ferr_q | ~rx_sync_q;
                    ferr_d   = frame_fe;
                    if (bit_q == StopLast) begin
                        bit_d    = '0;
                        complete = 1'b1;
                        state_d  = frame_fe ? StBreakWait : StIdle;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StBreakWait: begin
                // A held-low line must return high before another start is recognised
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) valid_d = 1'b0;
        if (complete) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                pe_d    = perr_q;
                fe_d    = frame_fe;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            data_q    <= data_d;
            valid_q   <= valid_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;
    assign bus.overrun    = ovr_q;
endmodule
